// File: rtl/network_scheduler.sv
// Round-robin arbiter that time-shares one network inference instance between NREQ requesters,
// sequencing load, watchdogged wait, response handshake and a one-cycle network reset.
module network_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 120,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_d,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [3:0]              rsp_q,
    output logic                    rsp_err,
    output logic                    net_load,
    output logic [DW-1:0]           net_d,
    input  logic                    net_valid,
    input  logic [3:0]              net_q,
    output logic                    net_rst
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned TW  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_FLUSH} state_t;

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic            r_net_load, w_net_load_nxt;
    logic [DW-1:0]   r_net_d, w_net_d_nxt;
    logic [IDW-1:0]  r_cur_id, w_cur_id_nxt;
    logic [IDW-1:0]  r_last, w_last_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt, w_timer_inc;
    logic            r_rsp_valid, w_rsp_valid_nxt;
    logic [IDW-1:0]  r_rsp_id, w_rsp_id_nxt;
    logic [3:0]      r_rsp_q, w_rsp_q_nxt;
    logic            r_rsp_err, w_rsp_err_nxt;
    logic            r_net_rst, w_net_rst_nxt;

    logic            w_found;
    logic [IDW-1:0]  w_pick;
    logic [DW-1:0]   w_pick_d;
    logic [DW-1:0]   w_slot [NREQ];

    for (genvar gi = 0; gi < int'(NREQ); gi++) begin : g_slot
        assign w_slot[gi] = req_d[gi*DW +: DW];
    end

    // First active requester after the last one granted, wrapping at NREQ
    always_comb begin : p_pick
        int             cand;
        logic [IDW-1:0] cand_id;
        w_found  = 1'b0;
        w_pick   = '0;
        w_pick_d = '0;
        cand     = 0;
        cand_id  = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = int'(r_last) + k;
            if (cand >= int'(NREQ)) begin
                cand = cand - int'(NREQ);
            end
            cand_id = IDW'(cand);
            if (!w_found && req[cand_id]) begin
                w_found  = 1'b1;
                w_pick   = cand_id;
                w_pick_d = w_slot[cand_id];
            end
        end
    end

    // Timer counts cycles since net_load and sticks at all-ones
    assign w_timer_inc = (r_timer == {TW{1'b1}}) ? r_timer : r_timer + TW'(1);

    always_comb begin : p_fsm
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_net_load_nxt  = 1'b0;
        w_net_d_nxt     = r_net_d;
        w_cur_id_nxt    = r_cur_id;
        w_last_nxt      = r_last;
        w_timer_nxt     = r_timer;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_q_nxt     = r_rsp_q;
        w_rsp_err_nxt   = r_rsp_err;
        w_net_rst_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_ISSUE;
                    w_gnt_nxt      = NREQ'(1) << w_pick;
                    w_net_load_nxt = 1'b1;
                    w_net_d_nxt    = w_pick_d;
                    w_cur_id_nxt   = w_pick;
                    w_last_nxt     = w_pick;
                    w_timer_nxt    = '0;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_timer_nxt = w_timer_inc;
            end
            S_WAIT: begin
                w_timer_nxt = w_timer_inc;
                if (net_valid) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_id_nxt    = r_cur_id;
                    w_rsp_q_nxt     = net_q;
                    w_rsp_err_nxt   = 1'b0;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_id_nxt    = r_cur_id;
                    w_rsp_q_nxt     = 4'hF;
                    w_rsp_err_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_FLUSH;
                    w_rsp_valid_nxt = 1'b0;
                    w_net_rst_nxt   = 1'b1;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Network reset is held high in reset so the instance restarts clean on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt       <= '0;
            r_net_load  <= 1'b0;
            r_net_d     <= '0;
            r_cur_id    <= '0;
            r_last      <= IDW'(NREQ - 1);
            r_timer     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_q     <= '0;
            r_rsp_err   <= 1'b0;
            r_net_rst   <= 1'b1;
        end else begin
            r_gnt       <= w_gnt_nxt;
            r_net_load  <= w_net_load_nxt;
            r_net_d     <= w_net_d_nxt;
            r_cur_id    <= w_cur_id_nxt;
            r_last      <= w_last_nxt;
            r_timer     <= w_timer_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_q     <= w_rsp_q_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_net_rst   <= w_net_rst_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign net_load  = r_net_load;
    assign net_d     = r_net_d;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_q     = r_rsp_q;
    assign rsp_err   = r_rsp_err;
    assign net_rst   = r_net_rst;

endmodule

// File: doc/network_scheduler.md
# network_scheduler

Round-robin scheduler that shares one `network` inference instance among `NREQ` independent requesters. Each requester submits a 120-bit cube state and gets back the 4-bit classification tagged with its requester index. The block sequences the network: it issues `load`, waits for `valid` under a watchdog, returns the result, and re-arms the network with a one-cycle reset pulse. It sits between the solver front-ends and `network`, and owns that instance's `load`, `d` and reset inputs.

## Interface
- `NREQ`, 4: number of requesters (2..8); `IDW` = clog2(`NREQ`).
- `DW`, 120: cube state width; must match `network` input `d`.
- `TIMEOUT`, 4096: watchdog limit in cycles from `net_load` to `net_valid`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester request level; must stay high until that requester's `gnt` bit pulses.
- `req_d`  in  NREQ*DW  per-requester cube state; slice i is `[i*DW +: DW]`, held stable while `req[i]` is high.
- `gnt`  out  NREQ  one-hot, one-cycle acceptance pulse.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester the response belongs to.
- `rsp_q`  out  4  classification result (`4'hF` on timeout).
- `rsp_err`  out  1  1 = watchdog timeout, no valid result.
- `net_load`  out  1  drives `network.load`.
- `net_d`  out  DW  drives `network.d`.
- `net_valid`  in  1  from `network.valid`.
- `net_q`  in  4  from `network.q`.
- `net_rst`  out  1  active-high network reset; the integrator inverts it onto `network.rst_n`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, FLUSH. All outputs are registered.
- IDLE:
  - If any `req` bit is high, pick the first set bit searching from `last+1` upward, wrapping at `NREQ`.
  - Latch `req_d` slice → `net_d`, index → `cur_id`, and set `last` = index.
  - Go to ISSUE.
- ISSUE (1 cycle): `gnt[cur_id]`=1 and `net_load`=1. Clear timer. Go to WAIT.
- WAIT: timer increments each cycle. Both branches go to RESP.
  - `net_valid`=1: capture `rsp_q` = `net_q`, `rsp_err`=0.
  - Timer == `TIMEOUT`-1 without `net_valid`: `rsp_q`=`4'hF`, `rsp_err`=1.
  - Both true in the same cycle: `net_valid` wins.
- RESP: `rsp_valid`=1, with `rsp_id`/`rsp_q`/`rsp_err` stable. Stay until `rsp_valid & rsp_ready`, then go to FLUSH.
- FLUSH (1 cycle): `net_rst`=1. Go to IDLE.
- `net_d` holds the granted data from ISSUE through FLUSH and is only updated on a new grant.
- Requests arriving in any non-IDLE state wait. A request is never dropped. Withdrawing `req` before its `gnt` is allowed.
- Fairness: with all requesters permanently active, grants rotate 0,1,2,…,NREQ-1,0.
- Timer width is clog2(`TIMEOUT`). It saturates and never wraps.

## Timing
- Reset values (async assert): state=IDLE, `gnt`=0, `net_load`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_q`=0, `rsp_id`=0, `net_d`=0, `net_rst`=1, `last`=NREQ-1 so requester 0 has top priority.
- After `rst` deasserts, `net_rst` drops on the first clock edge.
- Timing is given in cycles from the edge where IDLE samples `req`:
  - Edge 0: IDLE samples `req` and latches.
  - Cycle 1: ISSUE, with `gnt` and `net_load` high.
  - Cycle 2 onward: WAIT.
  - Edge after `net_valid` is seen: `rsp_valid` rises.
- Minimum turnaround from `net_valid` to the next `net_load` is 4 cycles when `rsp_ready` is held high: RESP, FLUSH, IDLE, ISSUE.
- A requester must drop `req` no later than the cycle after its `gnt`. IDLE is ≥3 cycles after `gnt`, so there is no double grant.
- `rst` mid-transaction aborts immediately. No response is produced and `net_rst` is held high.

## Test plan
- **Single request:** `req`=0001, `req_d[0]`=X, and the network model returns `net_q`=4'h7 5 cycles after load. Required: `gnt`=0001 for 1 cycle; `net_load` 1 cycle with `net_d`=X; `rsp_valid` with `rsp_id`=0, `rsp_q`=7, `rsp_err`=0; one `net_rst` pulse after the handshake.
- **Round-robin:** `req`=1111 held; requesters drop `req` after `gnt` and re-raise it 1 cycle later. Required: grant order 0,1,2,3,0,1 and matching `rsp_id` sequence.
- **Backpressure:** `rsp_ready`=0 for 20 cycles. Required: `rsp_valid` and its data stable for all 20 cycles; no `net_load` or `net_rst` until the handshake; then FLUSH.
- **Timeout:** `TIMEOUT`=16 and `net_valid` never asserted. Required: `rsp_valid` 16 cycles after `net_load` with `rsp_err`=1, `rsp_q`=F; the next grant proceeds normally.
- **Simultaneous valid and timeout:** `net_valid` asserted exactly at timer=`TIMEOUT`-1. Required: `rsp_err`=0 and `rsp_q`=`net_q`.
- **Reset mid-WAIT:** assert `rst` during WAIT. Required: all outputs at reset values, `net_rst`=1, no `rsp_valid`; after release, `req`=0100 is granted to requester 2 in cycle 1.
